// File: rtl/cnn_layer_accel_pkg.sv
// Shared types and constants for the CNN layer accelerator result path.
package cnn_layer_accel_pkg;

    localparam int C_RESULT_WIDTH = 16;
    localparam int C_PACK_WIDTH   = 128;
    localparam int C_LANES        = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2
    } packer_state_t;

    typedef struct packed {
        logic [C_PACK_WIDTH-1:0] data;
        logic [C_LANES-1:0]      lane_mask;
        logic                    last;
    } packed_word_t;

    // Mask with lanes 0..lane set (lane 7 gives all ones).
    function automatic logic [C_LANES-1:0] lane_mask_upto(input logic [2:0] lane);
        return {C_LANES{1'b1}} >> (3'(C_LANES - 1) - lane);
    endfunction

endpackage

// File: rtl/cnn_layer_accel_sync_fifo.sv
// Single-clock first-word-fall-through FIFO of packed words.
// The head is presented as zero whenever the FIFO is empty, so storage
// needs no reset of its own.
module cnn_layer_accel_sync_fifo
    import cnn_layer_accel_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  packed_word_t           i_wdata,
    input  logic                   i_pop,
    output packed_word_t           o_rdata,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    packed_word_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !w_empty;
    // A push into a full FIFO is accepted when the head leaves in the same cycle.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    // Storage write; contents beyond the count are never observed.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer and occupancy tracking; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule

// File: rtl/cnn_layer_accel_result_packer.sv
// Packs the quad's 16-bit result stream eight to a 128-bit word, tracks the
// output row/column/depth of the next result, and buffers packed words in a
// small FIFO for writeback. The final partial word of a job is zero-padded
// and flagged with out_last.
module cnn_layer_accel_result_packer
    import cnn_layer_accel_pkg::*;
#(
    parameter int OUT_FIFO_DEPTH = 4,
    parameter int LANES          = C_LANES
) (
    input  logic                      clk_core,
    input  logic                      rst_n,
    input  logic                      job_start,
    input  logic [9:0]                num_output_rows_cfg,
    input  logic [9:0]                num_output_cols_cfg,
    input  logic [6:0]                num_kernels_cfg,
    output logic                      busy,
    output logic                      job_done,
    input  logic                      result_valid,
    output logic                      result_accept,
    input  logic [C_RESULT_WIDTH-1:0] result_data,
    output logic [9:0]                output_row,
    output logic [9:0]                output_col,
    output logic [6:0]                output_depth,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [C_PACK_WIDTH-1:0]   out_data,
    output logic [C_LANES-1:0]        out_lane_mask,
    output logic                      out_last
);

    localparam int LW = $clog2(LANES);
    localparam int FW = $clog2(OUT_FIFO_DEPTH) + 1;

    packer_state_t r_state;
    packer_state_t w_next_state;

    logic [9:0]              r_rows_m1;
    logic [9:0]              r_cols_m1;
    logic [6:0]              r_kern_m1;
    logic [9:0]              r_row;
    logic [9:0]              r_col;
    logic [6:0]              r_depth;
    logic [LW-1:0]           r_lane_cnt;
    logic [C_PACK_WIDTH-1:0] r_lanes;

    logic                    w_start;
    logic                    w_job_done;
    logic                    w_hs;
    logic                    w_col_end;
    logic                    w_row_end;
    logic                    w_depth_end;
    logic                    w_last_result;
    logic                    w_push;
    logic                    w_pop;
    logic [C_PACK_WIDTH-1:0] w_merged;
    packed_word_t            w_push_word;
    packed_word_t            w_head;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic [FW-1:0]           w_fifo_count;

    assign result_accept = (r_state == ACTIVE) && !w_fifo_full;
    assign w_hs          = result_valid && result_accept;

    assign w_col_end     = (r_col   == r_cols_m1);
    assign w_row_end     = (r_row   == r_rows_m1);
    assign w_depth_end   = (r_depth == r_kern_m1);
    assign w_last_result = w_hs && w_col_end && w_row_end && w_depth_end;

    // New result merged into its lane; lanes above it are still zero because
    // the lane register is cleared after every pushed word.
    assign w_merged = r_lanes | (C_PACK_WIDTH'(result_data) << (C_RESULT_WIDTH * r_lane_cnt));
    assign w_push   = w_hs && ((r_lane_cnt == LW'(LANES - 1)) || w_last_result);

    assign w_push_word.data      = w_merged;
    assign w_push_word.lane_mask = lane_mask_upto(r_lane_cnt);
    assign w_push_word.last      = w_last_result;

    assign w_pop = out_ready && !w_fifo_empty;

    // State register.
    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic plus the job start strobe and job_done pulse.
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_job_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (job_start) begin
                    w_start      = 1'b1;
                    w_next_state = ACTIVE;
                end
            end
            ACTIVE: begin
                if (w_last_result) begin
                    w_next_state = FLUSH;
                end
            end
            FLUSH: begin
                // The last word was pushed on entry, so an empty FIFO here
                // means it has already been taken downstream.
                if (w_fifo_count == '0) begin
                    w_job_done   = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Latch job geometry as last-index values; a zero field behaves as one.
    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            r_rows_m1 <= '0;
            r_cols_m1 <= '0;
            r_kern_m1 <= '0;
        end else if (w_start) begin
            r_rows_m1 <= (num_output_rows_cfg == '0) ? 10'd0 : num_output_rows_cfg - 10'd1;
            r_cols_m1 <= (num_output_cols_cfg == '0) ? 10'd0 : num_output_cols_cfg - 10'd1;
            r_kern_m1 <= (num_kernels_cfg     == '0) ? 7'd0  : num_kernels_cfg - 7'd1;
        end
    end

    // Position of the next result; holds at the final position once the job's last result is in.
    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            r_row   <= '0;
            r_col   <= '0;
            r_depth <= '0;
        end else if (w_start) begin
            r_row   <= '0;
            r_col   <= '0;
            r_depth <= '0;
        end else if (w_hs && !w_last_result) begin
            if (w_col_end) begin
                r_col <= '0;
                if (w_row_end) begin
                    r_row   <= '0;
                    r_depth <= r_depth + 7'd1;
                end else begin
                    r_row <= r_row + 10'd1;
                end
            end else begin
                r_col <= r_col + 10'd1;
            end
        end
    end

    // Lane accumulation; the register empties whenever a word is pushed.
    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            r_lane_cnt <= '0;
            r_lanes    <= '0;
        end else if (w_start) begin
            r_lane_cnt <= '0;
            r_lanes    <= '0;
        end else if (w_hs) begin
            if (w_push) begin
                r_lane_cnt <= '0;
                r_lanes    <= '0;
            end else begin
                r_lane_cnt <= r_lane_cnt + 1'b1;
                r_lanes    <= w_merged;
            end
        end
    end

    cnn_layer_accel_sync_fifo #(
        .DEPTH (OUT_FIFO_DEPTH)
    ) u_out_fifo (
        .clk     (clk_core),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (w_push_word),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign busy          = (r_state != IDLE);
    assign job_done      = w_job_done;
    assign output_row    = r_row;
    assign output_col    = r_col;
    assign output_depth  = r_depth;
    assign out_valid     = !w_fifo_empty;
    assign out_data      = w_head.data;
    assign out_lane_mask = w_head.lane_mask;
    assign out_last      = w_head.last;

endmodule
